// File: rtl/dmem_pkg.sv
// Shared constants and log-entry layout for the mips data-side responder.
package dmem_pkg;

  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_BUS_WIDTH  = 17;

  localparam int ADR_RESULT      = 255;
  localparam int ADR_CYCLE       = 254;
  localparam int ADR_STATUS      = 253;

  localparam int EXPECTED_RESULT = 210;

  typedef struct packed {
    logic [DMEM_BUS_WIDTH-1:0]  adr;
    logic [DMEM_DATA_WIDTH-1:0] data;
  } log_entry_t;

endpackage

// File: rtl/dmem_log_fifo.sv
// First-word-fall-through FIFO recording every store; full pushes are dropped
// and flagged, but a push alongside a pop on a full FIFO is accepted.
module dmem_log_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;
  logic             full_s;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
  assign push_ok_s = push && (!full_s || pop_ok_s);

  // storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (push && full_s && !pop_ok_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign dout     = mem_r[rd_ptr_r];
  assign valid    = (count_r != {CNT_W{1'b0}});
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-bus responder for the mips core: word RAM, result/cycle/status MMIO
// registers and a write-log FIFO that audits every store.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_BUS_WIDTH = 17,
  parameter int RAM_ADR_WIDTH  = 8,
  parameter int LOG_DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dmemread,
  input  logic                      dmemwrite,
  input  logic [DATA_BUS_WIDTH-1:0] dadr,
  input  logic [DATA_WIDTH-1:0]     dmemwd,
  output logic [DATA_WIDTH-1:0]     dmemrd,
  output logic                      done,
  output logic                      pass,
  output logic [DATA_WIDTH-1:0]     result,
  input  logic                      log_pop,
  output logic                      log_valid,
  output logic [DATA_BUS_WIDTH-1:0] log_adr,
  output logic [DATA_WIDTH-1:0]     log_data,
  output logic                      log_overflow
);

  localparam int CNT_W     = $clog2(LOG_DEPTH) + 1;
  localparam int LOG_W     = DATA_BUS_WIDTH + DATA_WIDTH;
  localparam int RAM_DEPTH = 2 ** RAM_ADR_WIDTH;

  logic [DATA_WIDTH-1:0]    ram_r [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]    result_r;
  logic [DATA_WIDTH-1:0]    cycle_r;
  logic                     done_r;
  logic                     pass_r;
  logic                     sel_result_s;
  logic                     sel_cycle_s;
  logic                     sel_status_s;
  logic                     sel_ram_s;
  logic [RAM_ADR_WIDTH-1:0] ram_idx_s;
  logic [DATA_WIDTH-1:0]    status_s;
  logic [DATA_WIDTH-1:0]    rd_word_s;
  logic [CNT_W-1:0]         log_count_s;
  logic [LOG_W-1:0]         log_dout_s;
  logic                     log_overflow_s;

  assign sel_result_s = (dadr == DATA_BUS_WIDTH'(ADR_RESULT));
  assign sel_cycle_s  = (dadr == DATA_BUS_WIDTH'(ADR_CYCLE));
  assign sel_status_s = (dadr == DATA_BUS_WIDTH'(ADR_STATUS));
  assign ram_idx_s    = dadr[RAM_ADR_WIDTH-1:0];
  // MMIO addresses shadow the top RAM words
  assign sel_ram_s    = (dadr[DATA_BUS_WIDTH-1:RAM_ADR_WIDTH] == {(DATA_BUS_WIDTH-RAM_ADR_WIDTH){1'b0}})
                        && !sel_result_s && !sel_cycle_s && !sel_status_s;

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (dmemwrite && sel_ram_s) begin
      ram_r[ram_idx_s] <= dmemwd;
    end
  end

  // first write to RESULT latches the value and the verdict together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_r <= {DATA_WIDTH{1'b0}};
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
    end else if (dmemwrite && sel_result_s && !done_r) begin
      result_r <= dmemwd;
      done_r   <= 1'b1;
      pass_r   <= (dmemwd == DATA_WIDTH'(EXPECTED_RESULT));
    end
  end

  // cycle counter: runs until done, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_r <= {DATA_WIDTH{1'b0}};
    end else if (!done_r && (cycle_r != {DATA_WIDTH{1'b1}})) begin
      cycle_r <= cycle_r + DATA_WIDTH'(1);
    end
  end

  // status word layout: {pad, fifo_count, log_overflow, done}
  always_comb begin
    status_s             = {DATA_WIDTH{1'b0}};
    status_s[0]          = done_r;
    status_s[1]          = log_overflow_s;
    status_s[CNT_W+1:2]  = log_count_s;
  end

  // read mux; RESULT is write-only and out-of-range addresses read zero
  always_comb begin
    rd_word_s = {DATA_WIDTH{1'b0}};
    if (sel_cycle_s) begin
      rd_word_s = cycle_r;
    end else if (sel_status_s) begin
      rd_word_s = status_s;
    end else if (sel_ram_s) begin
      rd_word_s = ram_r[ram_idx_s];
    end else begin
      rd_word_s = {DATA_WIDTH{1'b0}};
    end
  end

  assign dmemrd = dmemread ? rd_word_s : {DATA_WIDTH{1'b0}};

  dmem_log_fifo #(
    .WIDTH (LOG_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk      (clk),
    .reset    (reset),
    .push     (dmemwrite),
    .din      ({dadr, dmemwd}),
    .pop      (log_pop),
    .dout     (log_dout_s),
    .valid    (log_valid),
    .count    (log_count_s),
    .overflow (log_overflow_s)
  );

  assign log_adr      = log_dout_s[LOG_W-1:DATA_WIDTH];
  assign log_data     = log_dout_s[DATA_WIDTH-1:0];
  assign log_overflow = log_overflow_s;
  assign done         = done_r;
  assign pass         = pass_r;
  assign result       = result_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table for the basic map and
// hand-written sequences for FIFO fill, cycle freeze and mid-run reset.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmemread, dmemwrite, log_pop;
  logic [16:0] dadr;
  logic [31:0] dmemwd;
  logic [31:0] dmemrd, result, log_data;
  logic        done, pass, log_valid, log_overflow;
  logic [16:0] log_adr;

  int checks   = 0;
  int failures = 0;

  dmem_responder dut (
    .clk(clk), .reset(reset), .dmemread(dmemread), .dmemwrite(dmemwrite),
    .dadr(dadr), .dmemwd(dmemwd), .dmemrd(dmemrd), .done(done), .pass(pass),
    .result(result), .log_pop(log_pop), .log_valid(log_valid), .log_adr(log_adr),
    .log_data(log_data), .log_overflow(log_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, pop;
    logic [16:0] adr;
    logic [31:0] wd;
    logic [31:0] e_rd;
    logic        e_done, e_pass;
    logic [31:0] e_result;
    logic        e_valid;
    log_entry_t  e_head;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic pop,
                       input logic [16:0] adr, input logic [31:0] wd);
    dmemread  = rd;
    dmemwrite = wr;
    log_pop   = pop;
    dadr      = adr;
    dmemwd    = wd;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 17'd0, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic pop,
                              input logic [16:0] adr, input logic [31:0] wd,
                              input logic [31:0] e_rd, input logic e_done, input logic e_pass,
                              input logic [31:0] e_result, input logic e_valid,
                              input logic [16:0] h_adr, input logic [31:0] h_data);
    vec_t v;
    v.rd = rd; v.wr = wr; v.pop = pop; v.adr = adr; v.wd = wd;
    v.e_rd = e_rd; v.e_done = e_done; v.e_pass = e_pass; v.e_result = e_result;
    v.e_valid = e_valid; v.e_head.adr = h_adr; v.e_head.data = h_data;
    return v;
  endfunction

  initial begin
    int cyc_a;
    logic [16:0] exp_adr [8];
    logic [31:0] exp_dat [8];

    // each row: inputs, then outputs expected before this row's clock edge
    vecs[0]  = mk(0,0,0, 17'd0,   32'd0,      32'd0,      0,0, 32'd0,   0, 17'd0,   32'd0);
    vecs[1]  = mk(0,1,0, 17'd5,   32'h1234,   32'd0,      0,0, 32'd0,   0, 17'd0,   32'd0);
    vecs[2]  = mk(1,0,0, 17'd5,   32'd0,      32'h1234,   0,0, 32'd0,   1, 17'd5,   32'h1234);
    vecs[3]  = mk(1,1,0, 17'd5,   32'hBEEF,   32'h1234,   0,0, 32'd0,   1, 17'd5,   32'h1234);
    vecs[4]  = mk(1,0,0, 17'd5,   32'd0,      32'hBEEF,   0,0, 32'd0,   1, 17'd5,   32'h1234);
    vecs[5]  = mk(1,1,0, 17'd300, 32'h55,     32'd0,      0,0, 32'd0,   1, 17'd5,   32'h1234);
    vecs[6]  = mk(1,0,0, 17'd300, 32'd0,      32'd0,      0,0, 32'd0,   1, 17'd5,   32'h1234);
    vecs[7]  = mk(0,1,0, 17'd255, 32'd210,    32'd0,      0,0, 32'd0,   1, 17'd5,   32'h1234);
    vecs[8]  = mk(1,0,0, 17'd255, 32'd0,      32'd0,      1,1, 32'd210, 1, 17'd5,   32'h1234);
    vecs[9]  = mk(0,1,0, 17'd255, 32'd7,      32'd0,      1,1, 32'd210, 1, 17'd5,   32'h1234);
    vecs[10] = mk(1,0,0, 17'd253, 32'd0,      32'd21,     1,1, 32'd210, 1, 17'd5,   32'h1234);
    vecs[11] = mk(0,0,1, 17'd0,   32'd0,      32'd0,      1,1, 32'd210, 1, 17'd5,   32'h1234);
    vecs[12] = mk(0,0,1, 17'd0,   32'd0,      32'd0,      1,1, 32'd210, 1, 17'd5,   32'hBEEF);
    vecs[13] = mk(1,0,0, 17'd253, 32'd0,      32'd13,     1,1, 32'd210, 1, 17'd300, 32'h55);
    vecs[14] = mk(0,1,0, 17'd252, 32'hA5A5,   32'd0,      1,1, 32'd210, 1, 17'd300, 32'h55);
    vecs[15] = mk(1,0,0, 17'd252, 32'd0,      32'hA5A5,   1,1, 32'd210, 1, 17'd300, 32'h55);
    vecs[16] = mk(0,1,0, 17'd0,   32'h11,     32'd0,      1,1, 32'd210, 1, 17'd300, 32'h55);
    vecs[17] = mk(1,0,0, 17'd0,   32'd0,      32'h11,     1,1, 32'd210, 1, 17'd300, 32'h55);

    reset = 1'b1;
    do_reset();
    chk("reset_overflow", log_overflow, 1'b0);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].pop, vecs[i].adr, vecs[i].wd);
      #2;
      chk($sformatf("v%0d_dmemrd", i), dmemrd, vecs[i].e_rd);
      chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
      chk($sformatf("v%0d_pass", i), pass, vecs[i].e_pass);
      chk($sformatf("v%0d_result", i), result, vecs[i].e_result);
      chk($sformatf("v%0d_valid", i), log_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_log_adr", i), log_adr, vecs[i].e_head.adr);
        chk($sformatf("v%0d_log_data", i), log_data, vecs[i].e_head.data);
      end
      tick();
    end

    // wrong first result: done without pass
    do_reset();
    drive(0, 1, 0, 17'd255, 32'd99);
    tick();
    drive(1, 0, 0, 17'd253, 32'd0);
    #2;
    chk("bad_done", done, 1'b1);
    chk("bad_pass", pass, 1'b0);
    chk("bad_result", result, 32'd99);
    chk("bad_status_lsb", dmemrd[0], 1'b1);

    // fill the log past capacity
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0, 17'(10 + i), 32'(100 + i));
      tick();
    end
    drive(1, 0, 0, 17'd253, 32'd0);
    #2;
    chk("full_status", dmemrd, 32'd34);
    chk("full_overflow", log_overflow, 1'b1);
    chk("full_head_adr", log_adr, 17'd10);
    chk("full_head_data", log_data, 32'd100);
    drive(0, 1, 1, 17'd50, 32'd1);
    tick();
    drive(1, 0, 0, 17'd253, 32'd0);
    #2;
    chk("pushpop_status", dmemrd, 32'd34);
    for (int k = 0; k < 7; k++) begin
      exp_adr[k] = 17'(11 + k);
      exp_dat[k] = 32'(101 + k);
    end
    exp_adr[7] = 17'd50;
    exp_dat[7] = 32'd1;
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 1, 17'd0, 32'd0);
      #2;
      chk($sformatf("drain%0d_valid", k), log_valid, 1'b1);
      chk($sformatf("drain%0d_adr", k), log_adr, exp_adr[k]);
      chk($sformatf("drain%0d_data", k), log_data, exp_dat[k]);
      tick();
    end
    drive(0, 0, 1, 17'd0, 32'd0);
    tick();
    drive(1, 0, 0, 17'd253, 32'd0);
    #2;
    chk("empty_pop_valid", log_valid, 1'b0);
    chk("empty_pop_status", dmemrd, 32'd2);

    // cycle counter runs, then freezes on done
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    drive(1, 0, 0, 17'd254, 32'd0);
    #2;
    checks++;
    if (dmemrd < 32'd19 || dmemrd > 32'd21) begin
      failures++;
      $display("FAIL cycle20: got %0d expected 20+-1", dmemrd);
    end
    tick();
    drive(0, 1, 0, 17'd255, 32'd1);
    tick();
    drive(1, 0, 0, 17'd254, 32'd0);
    #2;
    cyc_a = int'(dmemrd);
    chk("cycle_at_done", dmemrd, 32'd22);
    for (int i = 0; i < 5; i++) tick();
    #2;
    chk("cycle_frozen", dmemrd, 32'(cyc_a));

    // asynchronous reset in the middle of activity
    do_reset();
    drive(0, 1, 0, 17'd5, 32'hCAFE);
    tick();
    drive(0, 1, 0, 17'd255, 32'd210);
    tick();
    drive(0, 1, 0, 17'd6, 32'h66);
    tick();
    drive(1, 0, 0, 17'd253, 32'd0);
    #2;
    chk("pre_reset_status", dmemrd, 32'd13);
    reset = 1'b1;
    #1;
    chk("async_done", done, 1'b0);
    chk("async_pass", pass, 1'b0);
    chk("async_result", result, 32'd0);
    chk("async_valid", log_valid, 1'b0);
    chk("async_overflow", log_overflow, 1'b0);
    chk("async_status", dmemrd, 32'd0);
    tick();
    reset = 1'b0;
    drive(1, 0, 0, 17'd254, 32'd0);
    #1;
    chk("post_reset_cycle", dmemrd, 32'd0);
    drive(1, 0, 0, 17'd5, 32'd0);
    #1;
    chk("ram_retained", dmemrd, 32'hCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
